// File: rtl/keypad_press_gen.sv
// Keypad press generator: turns a {key, hold, bounce} request into the 4-bit
// keypad line code, with optional contact bounce and a trailing idle gap.
module keypad_press_gen #(
   parameter int BOUNCE_LEN = 6,
   parameter int GAP_CYCLES = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_key,
   input  logic [15:0] req_hold,
   input  logic        req_bounce,
   output logic [3:0]  key_out,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int PMAX = (BOUNCE_LEN > GAP_CYCLES) ? BOUNCE_LEN : GAP_CYCLES;
   localparam int PW   = $clog2(PMAX);
   localparam logic [PW-1:0] B_LAST = PW'(BOUNCE_LEN - 1);
   localparam logic [PW-1:0] G_LAST = PW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      BOUNCE_IN,
      HOLD,
      BOUNCE_OUT,
      GAP
   } state_t;

   state_t      state, state_nx;
   logic [PW-1:0] phase, phase_nx;
   logic [15:0] hold_cnt, hold_nx;
   logic [3:0]  code, code_nx;
   logic        bounce, bounce_nx;
   logic [3:0]  key_nx;
   logic        done_nx, err_nx;

   // Key D maps to 1111, which doubles as the idle code and is never emitted.
   function automatic logic [3:0] encode(input logic [3:0] k);
      logic [3:0] c;
      case (k)
         4'h1:    c = 4'b0000;
         4'h2:    c = 4'b0001;
         4'h3:    c = 4'b0010;
         4'hA:    c = 4'b0011;
         4'h4:    c = 4'b0100;
         4'h5:    c = 4'b0101;
         4'h6:    c = 4'b0110;
         4'hB:    c = 4'b0111;
         4'h7:    c = 4'b1000;
         4'h8:    c = 4'b1001;
         4'h9:    c = 4'b1010;
         4'hC:    c = 4'b1011;
         4'hF:    c = 4'b1100;
         4'h0:    c = 4'b1101;
         4'hE:    c = 4'b1110;
         default: c = 4'b1111;
      endcase
      return c;
   endfunction

   assign req_ready = (state == IDLE);
   assign busy      = ~req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         phase    <= '0;
         hold_cnt <= '0;
         code     <= '1;
         bounce   <= 1'b0;
         key_out  <= 4'hF;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nx;
         phase    <= phase_nx;
         hold_cnt <= hold_nx;
         code     <= code_nx;
         bounce   <= bounce_nx;
         key_out  <= key_nx;
         done     <= done_nx;
         err      <= err_nx;
      end
   end

   // hold_cnt is loaded with the press length and counts down to 1 in HOLD.
   always_comb begin
      state_nx  = state;
      phase_nx  = phase;
      hold_nx   = hold_cnt;
      code_nx   = code;
      bounce_nx = bounce;
      case (state)
         IDLE: begin
            if (req_valid && (req_key != 4'hD)) begin
               code_nx   = encode(req_key);
               hold_nx   = (req_hold == 16'd0) ? 16'd1 : req_hold;
               bounce_nx = req_bounce;
               phase_nx  = '0;
               state_nx  = req_bounce ? BOUNCE_IN : HOLD;
            end
         end
         BOUNCE_IN: begin
            if (phase == B_LAST) begin
               phase_nx = '0;
               state_nx = HOLD;
            end else begin
               phase_nx = phase + 1'b1;
            end
         end
         HOLD: begin
            if (hold_cnt <= 16'd1) begin
               hold_nx  = '0;
               phase_nx = '0;
               state_nx = bounce ? BOUNCE_OUT : GAP;
            end else begin
               hold_nx = hold_cnt - 16'd1;
            end
         end
         BOUNCE_OUT: begin
            if (phase == B_LAST) begin
               phase_nx = '0;
               state_nx = GAP;
            end else begin
               phase_nx = phase + 1'b1;
            end
         end
         GAP: begin
            if (phase == G_LAST) begin
               phase_nx = '0;
               state_nx = IDLE;
            end else begin
               phase_nx = phase + 1'b1;
            end
         end
         default: begin
            phase_nx = '0;
            state_nx = IDLE;
         end
      endcase
   end

   // Outputs are registered, so they are derived from the upcoming state.
   always_comb begin
      key_nx = 4'hF;
      case (state_nx)
         BOUNCE_IN:  key_nx = phase_nx[0] ? 4'hF : code_nx;
         HOLD:       key_nx = code_nx;
         BOUNCE_OUT: key_nx = phase_nx[0] ? code_nx : 4'hF;
         default:    key_nx = 4'hF;
      endcase
      done_nx = (state == GAP) && (state_nx == IDLE);
      err_nx  = (state == IDLE) && req_valid && (req_key == 4'hD);
   end

endmodule

// File: tb/tb_keypad_press_gen.sv
// Bench for keypad_press_gen: directed table, hand-written corner sequences and
// randomized traffic checked every cycle against a queue-based output model.
module tb_keypad_press_gen;

   localparam int B = 6;
   localparam int G = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_key = 4'h0;
   logic [15:0] req_hold = 16'd0;
   logic        req_bounce = 1'b0;
   logic [3:0]  key_out;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   keypad_press_gen #(.BOUNCE_LEN(B), .GAP_CYCLES(G)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_key    (req_key),
      .req_hold   (req_hold),
      .req_bounce (req_bounce),
      .key_out    (key_out),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Line code indexed by key value; D has none.
   logic [3:0] enc_tab [16] = '{4'hD, 4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8,
                                4'h9, 4'hA, 4'h3, 4'h7, 4'hB, 4'hF, 4'hE, 4'hC};

   // Reference model: one queue entry per future cycle of line code.
   logic [3:0] q [$];
   bit         cur_busy = 1'b0;
   bit         nb;
   logic [3:0] e_key = 4'hF;
   bit         e_done = 1'b0;
   bit         e_err = 1'b0;

   task automatic push_seq(input logic [3:0] k, input logic [15:0] h, input logic b);
      logic [3:0] c;
      int hh;
      c  = enc_tab[k];
      hh = (h == 16'd0) ? 1 : int'(h);
      if (b) for (int i = 0; i < B; i++) q.push_back((i % 2 == 0) ? c : 4'hF);
      for (int i = 0; i < hh; i++) q.push_back(c);
      if (b) for (int i = 0; i < B; i++) q.push_back((i % 2 == 0) ? 4'hF : c);
      for (int i = 0; i < G; i++) q.push_back(4'hF);
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         cur_busy = 1'b0;
         e_key    = 4'hF;
         e_done   = 1'b0;
         e_err    = 1'b0;
      end else begin
         e_err = 1'b0;
         if (!cur_busy && req_valid) begin
            if (req_key == 4'hD) e_err = 1'b1;
            else push_seq(req_key, req_hold, req_bounce);
         end
         if (q.size() != 0) begin
            e_key = q.pop_front();
            nb    = 1'b1;
         end else begin
            e_key = 4'hF;
            nb    = 1'b0;
         end
         e_done   = cur_busy && !nb;
         cur_busy = nb;
      end
      #1;
      chk("mon_key_out", int'(key_out), int'(e_key));
      chk("mon_ready", int'(req_ready), int'(!cur_busy));
      chk("mon_busy", int'(busy), int'(cur_busy));
      chk("mon_done", int'(done), int'(e_done));
      chk("mon_err", int'(err), int'(e_err));
   end

   // Returns in the cycle after the handshake edge with req_valid dropped.
   task automatic send(input logic [3:0] k, input logic [15:0] h, input logic b);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("send_ready_timeout", 0, 1);
      req_valid  = 1'b1;
      req_key    = k;
      req_hold   = h;
      req_bounce = b;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  key;
      logic [15:0] hold;
      logic        bounce;
      logic [3:0]  code;
      logic        rej;
      int          lat;
   } vec_t;

   vec_t vt [9];
   logic [3:0] bseq [28] = '{4'h3, 4'hF, 4'h3, 4'hF, 4'h3, 4'hF,
                             4'h3, 4'h3, 4'h3, 4'h3,
                             4'hF, 4'h3, 4'hF, 4'h3, 4'hF, 4'h3,
                             4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                             4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int n;
      int cnt_d;
      int cnt_e;
      int run;
      logic [3:0] first;
      logic       e1;

      vt[0] = '{4'h7, 16'd5, 1'b0, 4'h8, 1'b0, 18};
      vt[1] = '{4'hA, 16'd4, 1'b1, 4'h3, 1'b0, 29};
      vt[2] = '{4'h0, 16'd0, 1'b0, 4'hD, 1'b0, 14};
      vt[3] = '{4'hD, 16'd5, 1'b0, 4'hF, 1'b1, 0};
      vt[4] = '{4'h5, 16'd3, 1'b1, 4'h5, 1'b0, 28};
      vt[5] = '{4'hF, 16'd1, 1'b0, 4'hC, 1'b0, 14};
      vt[6] = '{4'hE, 16'd2, 1'b0, 4'hE, 1'b0, 15};
      vt[7] = '{4'h9, 16'd3, 1'b0, 4'hA, 1'b0, 16};
      vt[8] = '{4'hC, 16'd0, 1'b1, 4'hB, 1'b0, 26};

      repeat (3) @(negedge clk);
      chk("reset_key_out", int'(key_out), 15);
      chk("reset_ready", int'(req_ready), 1);
      chk("reset_busy", int'(busy), 0);
      rst_n = 1'b1;

      // Directed table
      for (int r = 0; r < 9; r++) begin
         send(vt[r].key, vt[r].hold, vt[r].bounce);
         first = key_out;
         e1    = err;
         chk($sformatf("vec%0d_first_key", r), int'(first), int'(vt[r].code));
         chk($sformatf("vec%0d_err", r), int'(e1), int'(vt[r].rej));
         if (vt[r].rej) begin
            cnt_d = 0;
            cnt_e = 0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               cnt_d += int'(done);
               cnt_e += int'(err);
               if (key_out != 4'hF) cnt_e++;
            end
            chk($sformatf("vec%0d_no_done", r), cnt_d, 0);
            chk($sformatf("vec%0d_quiet", r), cnt_e, 0);
         end else begin
            lat = 1;
            while (!done && lat < 200) begin
               @(negedge clk);
               lat++;
            end
            chk($sformatf("vec%0d_done_lat", r), lat, vt[r].lat);
         end
      end

      // Bounce press, exact line sequence
      send(4'hA, 16'd4, 1'b1);
      cnt_d = 0;
      for (int i = 0; i < 28; i++) begin
         chk($sformatf("bounce_seq%0d", i), int'(key_out), int'(bseq[i]));
         cnt_d += int'(done);
         @(negedge clk);
      end
      chk("bounce_done_cycle", int'(done), 1);
      cnt_d += int'(done);
      repeat (5) begin
         @(negedge clk);
         cnt_d += int'(done);
      end
      chk("bounce_done_once", cnt_d, 1);

      // Reset in the middle of a long hold
      send(4'h5, 16'd100, 1'b0);
      repeat (39) @(negedge clk);
      chk("prereset_key", int'(key_out), 5);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_key_out", int'(key_out), 15);
      chk("midrst_ready", int'(req_ready), 1);
      chk("midrst_done", int'(done), 0);
      chk("midrst_err", int'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(4'h9, 16'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("postrst_key%0d", i), int'(key_out), 10);
         @(negedge clk);
      end
      chk("postrst_release", int'(key_out), 15);
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("postrst_done_seen", int'(done), 1);

      // Back-to-back with req_valid held high
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      req_valid  = 1'b1;
      req_key    = 4'h1;
      req_hold   = 16'd3;
      req_bounce = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_key = 4'hF;
      chk("b2b_first_key", int'(key_out), 0);
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_done_lat", n, 15);
      chk("b2b_ready_in_done", int'(req_ready), 1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_second_key", int'(key_out), 12);
      n = 1;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_second_lat", n, 16);

      // Press length against a debounce limit of 10 (needs hold >= 12)
      for (int t = 0; t < 2; t++) begin
         send(4'h8, (t == 0) ? 16'd20 : 16'd10, 1'b0);
         run = 0;
         while (key_out == 4'h9 && run < 100) begin
            run++;
            @(negedge clk);
         end
         chk($sformatf("loop%0d_run", t), run, (t == 0) ? 20 : 10);
         chk($sformatf("loop%0d_decodable", t), int'(run >= 12), (t == 0) ? 1 : 0);
      end

      // Randomized traffic, checked by the per-cycle model
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         req_valid  = ($urandom_range(0, 3) == 0);
         req_key    = 4'($urandom_range(0, 15));
         req_hold   = 16'($urandom_range(0, 6));
         req_bounce = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("final_idle", int'(req_ready), 1);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
